// File: rtl/fifo_rw_ctrl.sv
// Fill/drain sequencer for a wrreq/rdreq FIFO: writes an incrementing pattern until full,
// reads it back until empty, and reports pass/fail, error count and word count.
module fifo_rw_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wrempty,
  input  logic              wrfull,
  output logic              wrreq,
  output logic [DATA_W-1:0] data,
  input  logic              rdempty,
  input  logic              rdfull,
  output logic              rdreq,
  input  logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, WAIT_EMPTY, FILL, WAIT_RDFULL, DRAIN, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] exp_data;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_vld;
  logic [WD_W-1:0]   wd;
  logic              wd_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the request strobes, which must react to the flags in the same cycle.
  always_comb begin
    state_nxt = state;
    wrreq     = 1'b0;
    rdreq     = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = WAIT_EMPTY;
      WAIT_EMPTY: begin
        if (wrempty) state_nxt = FILL;
        else if (wd == WD_LAST) begin
          wd_fire   = 1'b1;
          state_nxt = DONE;
        end
      end
      FILL: begin
        wrreq = !wrfull;
        if (wrfull) state_nxt = WAIT_RDFULL;
      end
      WAIT_RDFULL: begin
        if (rdfull) state_nxt = DRAIN;
        else if (wd == WD_LAST) begin
          wd_fire   = 1'b1;
          state_nxt = DONE;
        end
      end
      DRAIN: begin
        rdreq = !rdempty;
        if (rdempty && !rd_vld) state_nxt = DONE;
        else if (wd == WD_LAST && !rd_vld) begin
          wd_fire   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data     <= '0;
      exp_data <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      err_cnt  <= '0;
      rd_vld   <= 1'b0;
      wd       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done   <= (state_nxt == DONE);
      busy   <= state_nxt inside {WAIT_EMPTY, FILL, WAIT_RDFULL, DRAIN};
      rd_vld <= rdreq;

      // Watchdog measures time without progress in the waiting states.
      if (state_nxt != state || (state == DRAIN && rd_vld)) wd <= '0;
      else if (state inside {WAIT_EMPTY, WAIT_RDFULL, DRAIN}) wd <= wd + WD_W'(1);

      if (state == IDLE && start) begin
        data     <= '0;
        exp_data <= '0;
        wr_cnt   <= '0;
        rd_cnt   <= '0;
        err_cnt  <= '0;
        timeout  <= 1'b0;
        pass     <= 1'b0;
      end

      if (wrreq) begin
        data <= data + DATA_W'(1);
        if (wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + CNT_W'(1);
      end

      // Read data lands one cycle after rdreq; check it against the pattern.
      if (rd_vld) begin
        if (q != exp_data && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
        exp_data <= exp_data + DATA_W'(1);
        if (rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + CNT_W'(1);
      end

      if (wd_fire) timeout <= 1'b1;
      if (state_nxt == DONE)
        pass <= (err_cnt == '0) && (rd_cnt == wr_cnt) && !wd_fire;
    end
  end

endmodule

// File: tb/tb_fifo_rw_ctrl.sv
// Bench for fifo_rw_ctrl: behavioural FIFO with fault injection, expected pass results
// queued at stimulus time and compared by a monitor whenever done pulses.
module tb_fifo_rw_ctrl;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              wrempty, wrfull, rdempty, rdfull;
  logic              wrreq, rdreq;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q = '0;
  logic              busy, done, pass, timeout;
  logic [CNT_W-1:0]  err_cnt, wr_cnt;

  fifo_rw_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wrempty(wrempty), .wrfull(wrfull), .wrreq(wrreq), .data(data),
    .rdempty(rdempty), .rdfull(rdfull), .rdreq(rdreq), .q(q),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pass;
    int err;
    int wr;
    int rd;
    bit tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  exp_t last_e;

  int checks = 0;
  int failures = 0;

  // FIFO model state and fault knobs
  logic [DATA_W-1:0] mem[$];
  int  cnt = 0;
  int  depth = 256;
  int  m_wr = 0;
  int  m_rd = 0;
  int  corr_a = -1;
  int  corr_b = -1;
  bit  drop = 1'b0;
  bit  stuck = 1'b0;
  bit  flush = 1'b0;
  int  pcyc = 0;

  assign wrempty = !stuck && (cnt == 0);
  assign wrfull  = (cnt >= depth);
  assign rdfull  = (cnt >= depth);
  assign rdempty = (cnt == 0) || (drop && cnt == 1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic timed_out(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
    finish_run();
  endtask

  // Ideal single-clock FIFO, read data registered one cycle after rdreq.
  always @(posedge clk) begin
    logic [DATA_W-1:0] v;
    pcyc <= pcyc + 1;
    if (flush) begin
      mem.delete();
      cnt  <= 0;
      m_wr <= 0;
      m_rd <= 0;
    end else begin
      if (wrreq) begin
        check("wr_data", 32'(data), 32'(m_wr % 256));
        mem.push_back(data);
        m_wr <= m_wr + 1;
      end
      if (rdreq && mem.size() > 0) begin
        v = mem.pop_front();
        if (m_rd == corr_a || m_rd == corr_b) v = v ^ 8'h80;
        q <= v;
        m_rd <= m_rd + 1;
      end
      cnt <= mem.size();
    end
  end

  // Monitor: protocol invariants every cycle, result comparison on each done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_exclusive", 32'(wrreq && rdreq), 0);
      if (wrreq) check("wr_while_full", 32'(wrfull), 0);
      if (rdreq) check("rd_while_empty", 32'(rdempty), 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done with no queued expectation");
        end else begin
          me = exp_q.pop_front();
          check("pass", 32'(pass), 32'(me.pass));
          check("err_cnt", 32'(err_cnt), 32'(me.err));
          check("wr_cnt", 32'(wr_cnt), 32'(me.wr));
          check("timeout", 32'(timeout), 32'(me.tmo));
          check("model_writes", 32'(m_wr), 32'(me.wr));
          check("model_reads", 32'(m_rd), 32'(me.rd));
          last_e = me;
        end
      end
    end
  end

  // One pass; caller is positioned at a negedge with the DUT idle (or in its DONE->IDLE cycle).
  task automatic run_pass(input int d, input int ca, input int cb, input bit drp,
                          input bit stk, input bit poke);
    exp_t e;
    int   nrd;
    int   t1;
    int   budget;
    nrd   = stk ? 0 : d - (drp ? 1 : 0);
    e.wr  = stk ? 0 : d;
    e.rd  = nrd;
    e.err = ((ca >= 0 && ca < nrd) ? 1 : 0) + ((cb >= 0 && cb < nrd) ? 1 : 0);
    e.tmo = stk;
    e.pass = !stk && (e.err == 0) && (nrd == d);
    exp_q.push_back(e);

    depth = d; corr_a = ca; corr_b = cb; drop = drp; stuck = stk;
    flush = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    t1 = pcyc;
    check("busy_after_start", 32'(busy), 1);
    check("wrreq_in_wait_empty", 32'(wrreq), 0);
    @(negedge clk);
    if (!stk) check("first_wrreq", 32'(wrreq), 1);

    if (poke) begin
      budget = 2000;
      while (!(wrreq && m_wr >= d / 2) && budget > 0) begin @(negedge clk); budget--; end
      if (budget == 0) timed_out("poke_fill_wait");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      budget = 2000;
      while (!(rdreq && m_rd >= d / 2) && budget > 0) begin @(negedge clk); budget--; end
      if (budget == 0) timed_out("poke_drain_wait");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    budget = 4000;
    while (!done && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) timed_out("wait_done");
    if (stk) check("timeout_latency", 32'(pcyc - t1), TIMEOUT);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int budget;
    int d;
    int ca;
    #12;
    check("rst_wrreq", 32'(wrreq), 0);
    check("rst_rdreq", 32'(rdreq), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_data", 32'(data), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_wr_cnt", 32'(wr_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(256, -1, -1, 0, 0, 0);   // clean full-depth pass
    run_pass(256, 17, 200, 0, 0, 0);  // two corrupted words
    run_pass(16, -1, -1, 0, 0, 0);    // shallow FIFO
    run_pass(16, -1, -1, 0, 0, 0);    // back-to-back repeat
    run_pass(300, -1, -1, 0, 0, 0);   // pattern wraps past 0xFF
    run_pass(16, -1, -1, 0, 1, 0);    // wrempty stuck low: watchdog
    run_pass(256, -1, -1, 0, 0, 1);   // start pokes mid-fill and mid-drain

    // Reset in the middle of filling
    depth = 256; corr_a = -1; corr_b = -1; drop = 1'b0; stuck = 1'b0;
    flush = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    budget = 2000;
    while (!(wrreq && m_wr == 100) && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) timed_out("reset_point_wait");
    #1 rst_n = 1'b0;
    #1;
    check("midrst_wrreq", 32'(wrreq), 0);
    check("midrst_rdreq", 32'(rdreq), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pass", 32'(pass), 0);
    check("midrst_timeout", 32'(timeout), 0);
    check("midrst_data", 32'(data), 0);
    check("midrst_err_cnt", 32'(err_cnt), 0);
    check("midrst_wr_cnt", 32'(wr_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(256, -1, -1, 0, 0, 0);   // clean pass after reset
    run_pass(256, -1, -1, 1, 0, 0);   // one word never read back

    for (int i = 0; i < 4; i++) begin
      d  = int'($urandom_range(1, 40));
      ca = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, d - 1)) : -1;
      run_pass(d, ca, -1, 0, 0, 0);
    end

    // Results hold while idle
    repeat (5) @(negedge clk);
    check("hold_pass", 32'(pass), 32'(last_e.pass));
    check("hold_err_cnt", 32'(err_cnt), 32'(last_e.err));
    check("hold_wr_cnt", 32'(wr_cnt), 32'(last_e.wr));
    check("hold_busy", 32'(busy), 0);
    check("queue_drained", 32'(exp_q.size()), 0);
    finish_run();
  end

endmodule

// File: doc/fifo_rw_ctrl.md
# fifo_rw_ctrl

Self-checking sequencer for a single-clock FIFO of the wrreq/rdreq/full/empty style. On `start`, it fills the FIFO with an incrementing pattern until `wrfull`. It then drains the FIFO until `rdempty`, checking every word read against the expected pattern. It sits between the FIFO instance and the board-level status logic (LEDs/debug probe) and reports pass/fail, error count and word count.

## Interface
Parameters:
- `DATA_W`, 8: FIFO data width; pattern wraps modulo 2^DATA_W.
- `CNT_W`, 16: width of word and error counters.
- `TIMEOUT`, 1024: max cycles spent in any wait state before aborting.

Ports:
- `clk`: input, 1. System clock.
- `rst_n`: input, 1. Asynchronous active-low reset.
- `start`: input, 1. Single-cycle request to run one pass; ignored unless idle.
- `wrempty`: input, 1. FIFO write-side empty.
- `wrfull`: input, 1. FIFO write-side full.
- `wrreq`: output, 1. FIFO write request.
- `data`: output, DATA_W. FIFO write data.
- `rdempty`: input, 1. FIFO read-side empty.
- `rdfull`: input, 1. FIFO read-side full.
- `rdreq`: output, 1. FIFO read request.
- `q`: input, DATA_W. FIFO read data, valid the cycle after `rdreq` (normal mode, not show-ahead).
- `busy`: output, 1. High from the cycle after an accepted `start` until DONE.
- `done`: output, 1. One-cycle pulse at end of pass.
- `pass`: output, 1. Registered; valid from `done` until next `start`.
- `timeout`: output, 1. Registered; last pass aborted by watchdog.
- `err_cnt`: output, CNT_W. Data mismatches in last pass, saturating.
- `wr_cnt`: output, CNT_W. Words written in last pass, saturating.

## Operation
States:
- IDLE. `busy`=0. On `start`:
  - clear `data`, `expect`, `wr_cnt`, `rd_cnt`, `err_cnt`, `timeout`, `pass`;
  - go to WAIT_EMPTY.
- WAIT_EMPTY. When `wrempty`=1, go to FILL.
- FILL:
  - `wrreq` = !`wrfull` (combinational decode of state and flag).
  - Each cycle with `wrreq`=1, next cycle `data`+1 (wraps) and `wr_cnt`+1.
  - When `wrfull`=1, go to WAIT_RDFULL.
- WAIT_RDFULL. When `rdfull`=1, go to DRAIN.
- DRAIN:
  - `rdreq` = !`rdempty`. `rd_vld` is `rdreq` delayed one cycle.
  - On `rd_vld`: compare `q` to `expect`; on mismatch `err_cnt`+1 (saturating at all-ones).
  - On `rd_vld`: `expect`+1 (wraps) and `rd_cnt`+1.
  - When `rdempty`=1 and `rd_vld`=0, go to DONE.
- DONE:
  - `done`=1 for one cycle.
  - `pass` = (`err_cnt`==0) && (`rd_cnt`==`wr_cnt`) && !`timeout`.
  - Go to IDLE.

Watchdog:
- Counter cleared on every state change.
- In WAIT_EMPTY, WAIT_RDFULL and DRAIN, it increments each cycle.
- In DRAIN it is also cleared on each `rd_vld`.
- Reaching TIMEOUT-1 sets `timeout`=1 and goes to DONE.

Rules:
- `wrreq` and `rdreq` are never high simultaneously.
- `wrreq` and `rdreq` are never high in IDLE, WAIT_*, or DONE.
- `start` during any non-IDLE state: no effect.
- Writes are never issued while `wrfull`=1; reads are never issued while `rdempty`=1.
- `err_cnt`, `wr_cnt`, `pass` and `timeout` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values:
  - state IDLE; `wrreq`, `rdreq`, `busy`, `done`, `pass` and `timeout` all 0;
  - `data`, `err_cnt` and `wr_cnt` all 0;
  - internal `expect`, `rd_cnt`, `rd_vld` and watchdog all 0.
- Reset mid-pass: immediate return to IDLE with all reset values. `wrreq`/`rdreq` drop asynchronously with `rst_n`.
- `start` to WAIT_EMPTY: 1 cycle; `busy` rises the same edge.
- Empty FIFO: first `wrreq` appears 2 cycles after `start` (WAIT_EMPTY takes 1 cycle).
- `wrfull` deasserts `wrreq` in the same cycle (combinational).
- FILL exit is registered: 1 cycle after `wrfull` is seen.
- Last `rdreq` to DONE: 2 cycles (`rd_vld` drains, then the state change).
- `done` is high for exactly 1 cycle; `pass` is valid from that cycle.
- Back-to-back passes: `start` is accepted the cycle after `done`.
- Throughput: 1 word/cycle in FILL and in DRAIN.

## Test plan
- Ideal FIFO model, depth 256, DATA_W=8, `start` pulse:
  - 256 consecutive `wrreq` with data 0x00..0xFF, then 256 consecutive `rdreq`;
  - `done` then `pass`=1, `err_cnt`=0, `wr_cnt`=256, `timeout`=0.
- Model corrupts the word at read index 17 (0x11 to 0x91) and index 200:
  - `err_cnt`=2, `pass`=0, `wr_cnt`=256.
- Depth-16 model, DATA_W=4:
  - data wraps 0xF to 0x0 once, no false errors, `pass`=1;
  - second `start` the cycle after `done` gives an identical result.
- `wrempty` held 0:
  - `done` exactly TIMEOUT cycles after entering WAIT_EMPTY, `timeout`=1, `pass`=0, `wrreq` never asserted.
- `start` pulsed during FILL and during DRAIN:
  - no effect on counters or state;
  - assert `rst_n`=0 at FILL word 100: `wrreq`=0 at once, all outputs at reset values, next `start` runs a clean pass.
- Model drops one word (reads 255 words):
  - `rd_cnt`≠`wr_cnt`, so `pass`=0 even if `err_cnt`=0.
